graduation_list_mc: RTL and testbench
=====================================

Name:
graduation_list_mc

Overview:
- Parametrised successor of the single-slot graduation list. In-order completion buffer between rename/dispatch and commit.
- Accepts up to DISPATCH_WIDTH instructions per cycle and marks completions from NUM_WB writeback ports.
- Presents up to COMMIT_WIDTH oldest completed entries per cycle.
- Tracks the oldest pending exception with wrap-aware age comparison. Supports partial flush (branch mispredict) and full flush.

Parameters:
NUM_ENTRIES, 32, buffer depth; power of two, >=4
DISPATCH_WIDTH, 2, dispatch lanes per cycle (1..4)
COMMIT_WIDTH, 2, commit lanes per cycle (1..4)
NUM_WB, 4, writeback ports
PAYLOAD_W, 64, opaque per-entry payload width
IDX_W, $clog2(NUM_ENTRIES), index width (derived)

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
disp_valid_i  in  DISPATCH_WIDTH  lane valid; lanes contiguous from 0
disp_payload_i  in  DISPATCH_WIDTH*PAYLOAD_W  entry payload
disp_done_i  in  DISPATCH_WIDTH  entry complete at dispatch (store/AMO/vl=0)
disp_ex_i  in  DISPATCH_WIDTH  exception detected before dispatch
disp_ready_o  out  1  free entries >= DISPATCH_WIDTH
disp_index_o  out  DISPATCH_WIDTH*IDX_W  index assigned to lane k (tail+k)
wb_valid_i  in  NUM_WB  completion strobe
wb_index_i  in  NUM_WB*IDX_W  completed entry
wb_ex_i  in  NUM_WB  completion raised exception
commit_valid_o  out  COMMIT_WIDTH  lane k committable
commit_payload_o  out  COMMIT_WIDTH*PAYLOAD_W  payload of head+k
commit_ex_o  out  1  lane 0 carries exception
commit_head_o  out  IDX_W  head index
commit_ack_i  in  $clog2(COMMIT_WIDTH+1)  number of lanes retired this cycle
flush_i  in  1  partial flush
flush_index_i  in  IDX_W  youngest surviving entry
flush_all_i  in  1  drop everything
oldest_ex_valid_o  out  1  an exception is pending
oldest_ex_index_o  out  IDX_W  oldest excepting entry
count_o  out  IDX_W+1  occupied entries
empty_o / full_o  out  1  count==0 / count==NUM_ENTRIES

Behaviour:
Reset (async):
- head=tail=0, count=0, all valid/done/ex bits 0, all outputs 0.
- disp_ready_o=1 as soon as reset deasserts.

Age:
- age(i) = (i - head) mod NUM_ENTRIES; smaller is older.
- Entry i is occupied iff age(i) < count.

Dispatch:
- Accepted only if disp_ready_o && !flush_i && !flush_all_i. Each valid lane k is written at tail+k.
- Written entry gets done = disp_done_i|disp_ex_i and ex = disp_ex_i.
- tail advances by popcount(disp_valid_i), wrapping mod NUM_ENTRIES.
- Lanes that are not contiguous are a protocol error; an assertion fires.

Writeback:
- wb_valid_i to an occupied index sets done and ORs in ex.
- Writeback to an unoccupied index is ignored.
- Multiple ports hitting the same index: done set, ex ORed.
- A writeback in the same cycle as a dispatch to the same index is impossible by protocol.

Commit (combinational from registered state, zero latency):
- commit_valid_o[k]=1 iff entry head+k is occupied and done, and lanes 0..k-1 are valid and non-excepting.
- An excepting entry is presented only on lane 0, with commit_ex_o=1.
- commit_ack_i <= popcount(commit_valid_o); an assertion fires otherwise.
- head advances by commit_ack_i and the retired entries' valid bits clear.
- All commit outputs are 0 when flush_all_i=1.

Flush (priority flush_all_i > flush_i > normal):
- flush_all_i: head=tail=count=0 next cycle, exception tracker cleared; dispatch and writeback are ignored that cycle.
- flush_i: tail=flush_index_i+1 and head+=commit_ack_i, both in the same cycle.
  - count = (flush_index_i+1-new_head) mod NUM_ENTRIES.
  - If flush_index_i+1 == new_head with the buffer non-empty before the flush, count=NUM_ENTRIES (nothing flushed).
  - flush_index_i must be occupied and not among the acked entries.
- Writebacks to flushed entries in the flush cycle are discarded.

Oldest exception tracker:
- On each dispatch ex or wb ex, replace the tracker if it is empty or the new age is smaller; ties keep the current value.
- Cleared when its entry commits.
- Cleared on flush if its age > age(flush_index_i); cleared on flush_all_i.

Counters:
- count next = count + dispatched - commit_ack_i.
- Internal arithmetic is IDX_W+1 bits, truncated on wrap.

Decomposition:
- Shared package (drac_pkg): gl_index_t sized from NUM_ENTRIES; commit-count type.
- Sub-module gl_age_compare: combinational, inputs head, a, b; output a_older_than_b.
  - Used by the exception tracker and by the flush survivor check.

Test Plan:
- Reset, then dispatch 2/cycle for 16 cycles with done=1, ack 2/cycle -> disp_index_o sequence 0,1,2,...,31,0 wraps; count_o steady at 2; empty_o after drain.
- Fill to 32 with done=0 -> full_o=1, disp_ready_o=0 while count>30. Writeback index 1 only -> commit_valid_o=00. Then writeback index 0 -> commit_valid_o=11.
- Head=30, entries 30,31,0,1 occupied. wb_ex on 1, then on 31 -> oldest_ex_index_o=31. flush_index_i=30 -> tracker cleared, count=1, tail=31.
- Entry head excepting and head+1 done -> commit_valid_o=01, commit_ex_o=1. ack=1 -> oldest_ex_valid_o=0.
- flush_i with commit_ack_i=1 and head=4, flush_index_i=6 -> next head=5, tail=7, count=2. A writeback to index 8 the same cycle is ignored.
- Assert rstn_i mid-stream with count=10 -> all outputs 0 immediately. After release, first dispatch gets index 0.

Source files
------------

// File: rtl/graduation_list_mc_pkg.sv
// Shared types and helpers for the multi-lane graduation list.
package graduation_list_mc_pkg;

    localparam int unsigned GL_NUM_ENTRIES  = 32;
    localparam int unsigned GL_COMMIT_WIDTH = 2;

    typedef logic [$clog2(GL_NUM_ENTRIES)-1:0]    gl_index_t;
    typedef logic [$clog2(GL_COMMIT_WIDTH+1)-1:0] gl_commit_cnt_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/gl_age_compare.sv
// Wrap-aware age comparison: a is older than b when its distance from head is smaller.
module gl_age_compare #(
    parameter int unsigned IDX_W = 5
) (
    input  logic [IDX_W-1:0] head,
    input  logic [IDX_W-1:0] a,
    input  logic [IDX_W-1:0] b,
    output logic             a_older_than_b
);

    logic [IDX_W-1:0] age_a_s;
    logic [IDX_W-1:0] age_b_s;

    assign age_a_s        = a - head;
    assign age_b_s        = b - head;
    assign a_older_than_b = age_a_s < age_b_s;

endmodule

// File: rtl/graduation_list_mc_chk.sv
// Protocol checks on the dispatch and commit handshakes of the graduation list.
module graduation_list_mc_chk #(
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned ACK_W          = 2
) (
    input logic                      clk_i,
    input logic                      rstn_i,
    input logic [DISPATCH_WIDTH-1:0] disp_valid,
    input logic [COMMIT_WIDTH-1:0]   commit_valid,
    input logic [ACK_W-1:0]          commit_ack
);

    a_disp_contiguous: assert property (@(posedge clk_i) disable iff (!rstn_i)
        (disp_valid & (disp_valid + DISPATCH_WIDTH'(1))) == '0);

    a_ack_bound: assert property (@(posedge clk_i) disable iff (!rstn_i)
        int'(commit_ack) <= $countones(commit_valid));

endmodule

// File: rtl/graduation_list_mc.sv
// Multi-lane in-order graduation list: wide dispatch, multi-port writeback,
// wide in-order commit and oldest-exception tracking with partial/full flush.
module graduation_list_mc
    import graduation_list_mc_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES    = 32,
    parameter int unsigned DISPATCH_WIDTH = 2,
    parameter int unsigned COMMIT_WIDTH   = 2,
    parameter int unsigned NUM_WB         = 4,
    parameter int unsigned PAYLOAD_W      = 64,
    parameter int unsigned IDX_W          = $clog2(NUM_ENTRIES),
    parameter int unsigned ACK_W          = $clog2(COMMIT_WIDTH+1)
) (
    input  logic                                clk_i,
    input  logic                                rstn_i,
    input  logic [DISPATCH_WIDTH-1:0]           disp_valid_i,
    input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0] disp_payload_i,
    input  logic [DISPATCH_WIDTH-1:0]           disp_done_i,
    input  logic [DISPATCH_WIDTH-1:0]           disp_ex_i,
    output logic                                disp_ready_o,
    output logic [DISPATCH_WIDTH*IDX_W-1:0]     disp_index_o,
    input  logic [NUM_WB-1:0]                   wb_valid_i,
    input  logic [NUM_WB*IDX_W-1:0]             wb_index_i,
    input  logic [NUM_WB-1:0]                   wb_ex_i,
    output logic [COMMIT_WIDTH-1:0]             commit_valid_o,
    output logic [COMMIT_WIDTH*PAYLOAD_W-1:0]   commit_payload_o,
    output logic                                commit_ex_o,
    output logic [IDX_W-1:0]                    commit_head_o,
    input  logic [ACK_W-1:0]                    commit_ack_i,
    input  logic                                flush_i,
    input  logic [IDX_W-1:0]                    flush_index_i,
    input  logic                                flush_all_i,
    output logic                                oldest_ex_valid_o,
    output logic [IDX_W-1:0]                    oldest_ex_index_o,
    output logic [IDX_W:0]                      count_o,
    output logic                                empty_o,
    output logic                                full_o
);

    localparam int unsigned  NC    = DISPATCH_WIDTH + NUM_WB;
    localparam logic [IDX_W:0] DEPTH = (IDX_W+1)'(NUM_ENTRIES);

    logic [IDX_W-1:0]     head_r, tail_r;
    logic [IDX_W:0]       count_r;
    logic [NUM_ENTRIES-1:0] done_r, ex_r, done_n_s, ex_n_s;
    logic [PAYLOAD_W-1:0] payload_r [NUM_ENTRIES];
    logic                 oex_valid_r;
    logic [IDX_W-1:0]     oex_index_r;

    logic                 ready_s, disp_fire_s;
    logic [IDX_W:0]       free_s, n_disp_s, ack_s, flush_count_s;
    logic [IDX_W-1:0]     new_head_s, flush_diff_s, oex_age_s;
    logic [IDX_W-1:0]     lane_idx_s [DISPATCH_WIDTH];
    logic [IDX_W-1:0]     wb_idx_s [NUM_WB];
    logic [IDX_W-1:0]     wb_age_s [NUM_WB];
    logic [NUM_WB-1:0]    wb_flushed_s, wb_hit_s;
    logic [NC-1:0]        cand_v_s;
    logic [IDX_W-1:0]     cand_i_s [NC];
    logic                 oex_flushed_s, trk0_v_s, trk_v_s;
    logic [IDX_W-1:0]     trk_i_s;
    logic [COMMIT_WIDTH-1:0] commit_valid_s;

    assign free_s       = DEPTH - count_r;
    assign ready_s      = free_s >= (IDX_W+1)'(DISPATCH_WIDTH);
    assign disp_ready_o = rstn_i & ready_s;
    assign disp_fire_s  = ready_s & ~flush_i & ~flush_all_i;
    assign n_disp_s     = disp_fire_s ? (IDX_W+1)'(popcount8(8'(disp_valid_i))) : '0;
    assign ack_s        = (IDX_W+1)'(commit_ack_i);
    assign new_head_s   = head_r + IDX_W'(commit_ack_i);

    // A flush that lands exactly on the new head of a non-empty buffer keeps everything.
    assign flush_diff_s  = flush_index_i + IDX_W'(1) - new_head_s;
    assign flush_count_s = ((flush_diff_s == '0) && (count_r != '0)) ? DEPTH : {1'b0, flush_diff_s};

    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_disp
        assign lane_idx_s[k] = tail_r + IDX_W'(k);
        assign disp_index_o[k*IDX_W +: IDX_W] = rstn_i ? lane_idx_s[k] : '0;
        assign cand_v_s[k] = disp_fire_s & disp_valid_i[k] & disp_ex_i[k];
        assign cand_i_s[k] = lane_idx_s[k];
    end

    for (genvar w = 0; w < NUM_WB; w++) begin : g_wb
        assign wb_idx_s[w] = wb_index_i[w*IDX_W +: IDX_W];
        assign wb_age_s[w] = wb_idx_s[w] - head_r;
        gl_age_compare #(.IDX_W(IDX_W)) u_wb_flushed (
            .head(head_r), .a(flush_index_i), .b(wb_idx_s[w]), .a_older_than_b(wb_flushed_s[w])
        );
        assign wb_hit_s[w] = wb_valid_i[w] & ~flush_all_i & ({1'b0, wb_age_s[w]} < count_r)
                           & ~(flush_i & wb_flushed_s[w]);
        assign cand_v_s[DISPATCH_WIDTH+w] = wb_hit_s[w] & wb_ex_i[w];
        assign cand_i_s[DISPATCH_WIDTH+w] = wb_idx_s[w];
    end

    // Tracker survives only if its entry neither retires nor lies beyond the flush point.
    assign oex_age_s = oex_index_r - head_r;
    gl_age_compare #(.IDX_W(IDX_W)) u_oex_flushed (
        .head(head_r), .a(flush_index_i), .b(oex_index_r), .a_older_than_b(oex_flushed_s)
    );
    assign trk0_v_s = oex_valid_r & ~({1'b0, oex_age_s} < ack_s) & ~(flush_i & oex_flushed_s);

    for (genvar s = 0; s < NC; s++) begin : g_trk
        logic             v_in_s, v_out_s, older_s;
        logic [IDX_W-1:0] i_in_s, i_out_s;
        if (s == 0) begin : g_first
            assign v_in_s = trk0_v_s;
            assign i_in_s = oex_index_r;
        end else begin : g_next
            assign v_in_s = g_trk[s-1].v_out_s;
            assign i_in_s = g_trk[s-1].i_out_s;
        end
        gl_age_compare #(.IDX_W(IDX_W)) u_cmp (
            .head(head_r), .a(cand_i_s[s]), .b(i_in_s), .a_older_than_b(older_s)
        );
        assign v_out_s = v_in_s | cand_v_s[s];
        assign i_out_s = (cand_v_s[s] & (~v_in_s | older_s)) ? cand_i_s[s] : i_in_s;
    end
    assign trk_v_s = g_trk[NC-1].v_out_s;
    assign trk_i_s = g_trk[NC-1].i_out_s;

    // Lane k is offered only behind a chain of done, non-excepting older lanes.
    always_comb begin
        logic             chain_ok;
        logic [IDX_W-1:0] idx;
        commit_valid_s   = '0;
        commit_payload_o = '0;
        chain_ok         = 1'b1;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            idx = head_r + IDX_W'(k);
            commit_valid_s[k] = chain_ok & ((IDX_W+1)'(k) < count_r) & done_r[idx] & ((k == 0) | ~ex_r[idx]);
            chain_ok = commit_valid_s[k] & ~ex_r[idx];
            commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = (commit_valid_s[k] & ~flush_all_i) ? payload_r[idx] : '0;
        end
    end

    assign commit_valid_o    = flush_all_i ? '0 : commit_valid_s;
    assign commit_ex_o       = commit_valid_o[0] & ex_r[head_r];
    assign commit_head_o     = flush_all_i ? '0 : head_r;
    assign oldest_ex_valid_o = oex_valid_r;
    assign oldest_ex_index_o = oex_index_r;
    assign count_o           = count_r;
    assign empty_o           = rstn_i & (count_r == '0);
    assign full_o            = count_r == DEPTH;

    // Dispatch writes fresh completion state; writebacks set done and accumulate ex.
    always_comb begin
        done_n_s = done_r;
        ex_n_s   = ex_r;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            done_n_s[lane_idx_s[k]] = (disp_fire_s & disp_valid_i[k]) ? (disp_done_i[k] | disp_ex_i[k])
                                                                     : done_n_s[lane_idx_s[k]];
            ex_n_s[lane_idx_s[k]]   = (disp_fire_s & disp_valid_i[k]) ? disp_ex_i[k] : ex_n_s[lane_idx_s[k]];
        end
        for (int w = 0; w < NUM_WB; w++) begin
            done_n_s[wb_idx_s[w]] = done_n_s[wb_idx_s[w]] | wb_hit_s[w];
            ex_n_s[wb_idx_s[w]]   = ex_n_s[wb_idx_s[w]] | (wb_hit_s[w] & wb_ex_i[w]);
        end
    end

    // Pointer, occupancy and tracker state; flush_all wins over flush over normal flow.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            head_r      <= '0;
            tail_r      <= '0;
            count_r     <= '0;
            done_r      <= '0;
            ex_r        <= '0;
            oex_valid_r <= 1'b0;
            oex_index_r <= '0;
        end else begin
            done_r <= done_n_s;
            ex_r   <= ex_n_s;
            if (flush_all_i) begin
                head_r      <= '0;
                tail_r      <= '0;
                count_r     <= '0;
                oex_valid_r <= 1'b0;
                oex_index_r <= '0;
            end else if (flush_i) begin
                head_r      <= new_head_s;
                tail_r      <= flush_index_i + IDX_W'(1);
                count_r     <= flush_count_s;
                oex_valid_r <= trk_v_s;
                oex_index_r <= trk_i_s;
            end else begin
                head_r      <= new_head_s;
                tail_r      <= tail_r + IDX_W'(n_disp_s);
                count_r     <= count_r + n_disp_s - ack_s;
                oex_valid_r <= trk_v_s;
                oex_index_r <= trk_i_s;
            end
        end
    end

    // Payload capture for dispatched lanes.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                payload_r[e] <= '0;
            end
        end else begin
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                if (disp_fire_s && disp_valid_i[k]) begin
                    payload_r[lane_idx_s[k]] <= disp_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
                end
            end
        end
    end

    graduation_list_mc_chk #(
        .DISPATCH_WIDTH(DISPATCH_WIDTH), .COMMIT_WIDTH(COMMIT_WIDTH), .ACK_W(ACK_W)
    ) u_chk (
        .clk_i(clk_i), .rstn_i(rstn_i), .disp_valid(disp_valid_i),
        .commit_valid(commit_valid_o), .commit_ack(commit_ack_i)
    );

endmodule

// File: tb/tb_graduation_list_mc.sv
// Directed bench for graduation_list_mc with hand-computed expectations.
module tb_graduation_list_mc;
    import graduation_list_mc_pkg::*;

    logic           clk_i = 1'b0;
    logic           rstn_i = 1'b0;
    logic [1:0]     disp_valid_i, disp_done_i, disp_ex_i;
    logic [127:0]   disp_payload_i;
    logic           disp_ready_o;
    logic [9:0]     disp_index_o;
    logic [3:0]     wb_valid_i, wb_ex_i;
    logic [19:0]    wb_index_i;
    logic [1:0]     commit_valid_o;
    logic [127:0]   commit_payload_o;
    logic           commit_ex_o;
    gl_index_t      commit_head_o;
    gl_commit_cnt_t commit_ack_i;
    logic           flush_i, flush_all_i;
    gl_index_t      flush_index_i;
    logic           oldest_ex_valid_o;
    gl_index_t      oldest_ex_index_o;
    logic [5:0]     count_o;
    logic           empty_o, full_o;

    int n_checks = 0;
    int n_fail   = 0;

    graduation_list_mc dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .disp_valid_i(disp_valid_i), .disp_payload_i(disp_payload_i),
        .disp_done_i(disp_done_i), .disp_ex_i(disp_ex_i),
        .disp_ready_o(disp_ready_o), .disp_index_o(disp_index_o),
        .wb_valid_i(wb_valid_i), .wb_index_i(wb_index_i), .wb_ex_i(wb_ex_i),
        .commit_valid_o(commit_valid_o), .commit_payload_o(commit_payload_o),
        .commit_ex_o(commit_ex_o), .commit_head_o(commit_head_o), .commit_ack_i(commit_ack_i),
        .flush_i(flush_i), .flush_index_i(flush_index_i), .flush_all_i(flush_all_i),
        .oldest_ex_valid_o(oldest_ex_valid_o), .oldest_ex_index_o(oldest_ex_index_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        disp_valid_i   = 2'b00;
        disp_done_i    = 2'b00;
        disp_ex_i      = 2'b00;
        disp_payload_i = '0;
        wb_valid_i     = 4'b0000;
        wb_ex_i        = 4'b0000;
        wb_index_i     = '0;
        commit_ack_i   = 2'd0;
        flush_i        = 1'b0;
        flush_all_i    = 1'b0;
        flush_index_i  = 5'd0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wb(input int port, input logic [4:0] idx, input logic ex);
        wb_valid_i[port]          = 1'b1;
        wb_index_i[port*5 +: 5]   = idx;
        wb_ex_i[port]             = ex;
    endtask

    task automatic disp(input logic [1:0] v, input logic [1:0] done);
        disp_valid_i = v;
        disp_done_i  = done;
    endtask

    initial begin
        idle();
        #2;
        check_eq("rst_ready", disp_ready_o, 64'd0);
        check_eq("rst_count", count_o, 64'd0);
        check_eq("rst_cvalid", commit_valid_o, 64'd0);
        check_eq("rst_oex", oldest_ex_valid_o, 64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        #1;
        check_eq("rel_ready", disp_ready_o, 64'd1);
        check_eq("rel_empty", empty_o, 64'd1);

        // Streaming dispatch 2/cycle with immediate commit 2/cycle; indices wrap.
        for (int i = 0; i <= 16; i++) begin
            idle();
            if (i < 16) begin
                disp(2'b11, 2'b11);
                disp_payload_i = {64'(101 + 2*i), 64'(100 + 2*i)};
            end
            if (i > 0) commit_ack_i = 2'd2;
            #1;
            check_eq("t1_idx", disp_index_o, {5'((2*i+1) % 32), 5'((2*i) % 32)});
            if (i > 0) begin
                check_eq("t1_count", count_o, 64'd2);
                check_eq("t1_cvalid", commit_valid_o, 64'd3);
                check_eq("t1_pay0", commit_payload_o[63:0], 64'(100 + 2*(i-1)));
                check_eq("t1_pay1", commit_payload_o[127:64], 64'(101 + 2*(i-1)));
            end
            step();
        end
        idle();
        #1;
        check_eq("t1_drain_count", count_o, 64'd0);
        check_eq("t1_drain_empty", empty_o, 64'd1);

        // Fill to capacity with nothing done.
        for (int i = 0; i < 16; i++) begin
            idle();
            disp(2'b11, 2'b00);
            #1;
            if (i == 15) begin
                check_eq("t2_count30", count_o, 64'd30);
                check_eq("t2_ready30", disp_ready_o, 64'd1);
            end
            step();
        end
        idle();
        #1;
        check_eq("t2_full", full_o, 64'd1);
        check_eq("t2_ready_full", disp_ready_o, 64'd0);
        check_eq("t2_count32", count_o, 64'd32);
        wb(0, 5'd1, 1'b0);
        step();
        idle();
        #1;
        check_eq("t2_cvalid_wb1", commit_valid_o, 64'd0);
        wb(0, 5'd0, 1'b0);
        step();
        idle();
        #1;
        check_eq("t2_cvalid_wb0", commit_valid_o, 64'd3);

        // Full flush masks commit outputs immediately and empties next cycle.
        flush_all_i = 1'b1;
        #1;
        check_eq("t3_fa_cvalid", commit_valid_o, 64'd0);
        step();
        idle();
        #1;
        check_eq("t3_fa_count", count_o, 64'd0);
        check_eq("t3_fa_idx", disp_index_o, {5'd1, 5'd0});

        // Walk head to 30.
        for (int i = 0; i <= 15; i++) begin
            idle();
            if (i < 15) disp(2'b11, 2'b11);
            if (i > 0) commit_ack_i = 2'd2;
            step();
        end
        idle();
        #1;
        check_eq("t3_head30", commit_head_o, 64'd30);
        check_eq("t3_empty30", empty_o, 64'd1);
        disp(2'b11, 2'b00);
        #1;
        check_eq("t3_idx30", disp_index_o, {5'd31, 5'd30});
        step();
        idle();
        disp(2'b11, 2'b00);
        #1;
        check_eq("t3_idx0", disp_index_o, {5'd1, 5'd0});
        step();
        idle();
        wb(0, 5'd1, 1'b1);
        step();
        idle();
        #1;
        check_eq("t3_oex_v", oldest_ex_valid_o, 64'd1);
        check_eq("t3_oex_1", oldest_ex_index_o, 64'd1);
        wb(2, 5'd31, 1'b1);
        step();
        idle();
        #1;
        check_eq("t3_oex_31", oldest_ex_index_o, 64'd31);
        wb(1, 5'd0, 1'b1);
        step();
        idle();
        #1;
        check_eq("t3_oex_keep31", oldest_ex_index_o, 64'd31);
        flush_i       = 1'b1;
        flush_index_i = 5'd30;
        step();
        idle();
        #1;
        check_eq("t3_fl_oex", oldest_ex_valid_o, 64'd0);
        check_eq("t3_fl_count", count_o, 64'd1);
        check_eq("t3_fl_tail", disp_index_o, {5'd0, 5'd31});

        // Excepting head is presented alone on lane 0.
        disp(2'b01, 2'b01);
        step();
        idle();
        wb(0, 5'd30, 1'b1);
        step();
        idle();
        #1;
        check_eq("t4_cvalid", commit_valid_o, 64'd1);
        check_eq("t4_cex", commit_ex_o, 64'd1);
        check_eq("t4_oex_idx", oldest_ex_index_o, 64'd30);
        commit_ack_i = 2'd1;
        step();
        idle();
        #1;
        check_eq("t4_oex_clr", oldest_ex_valid_o, 64'd0);
        check_eq("t4_head31", commit_head_o, 64'd31);
        check_eq("t4_cvalid31", commit_valid_o, 64'd1);
        check_eq("t4_cex31", commit_ex_o, 64'd0);
        commit_ack_i = 2'd1;
        step();
        idle();
        #1;
        check_eq("t4_count0", count_o, 64'd0);

        // Partial flush together with a commit; writeback beyond the flush point is dropped.
        disp(2'b11, 2'b11);
        step();
        idle();
        disp(2'b11, 2'b11);
        commit_ack_i = 2'd2;
        step();
        idle();
        disp(2'b11, 2'b01);
        commit_ack_i = 2'd2;
        step();
        idle();
        disp(2'b11, 2'b00);
        step();
        idle();
        disp(2'b11, 2'b00);
        step();
        idle();
        #1;
        check_eq("t5_head4", commit_head_o, 64'd4);
        check_eq("t5_count6", count_o, 64'd6);
        check_eq("t5_cvalid", commit_valid_o, 64'd1);
        flush_i       = 1'b1;
        flush_index_i = 5'd6;
        commit_ack_i  = 2'd1;
        wb(0, 5'd5, 1'b0);
        wb(1, 5'd8, 1'b1);
        step();
        idle();
        #1;
        check_eq("t5_head5", commit_head_o, 64'd5);
        check_eq("t5_count2", count_o, 64'd2);
        check_eq("t5_tail7", disp_index_o[4:0], 64'd7);
        check_eq("t5_cvalid5", commit_valid_o, 64'd1);
        check_eq("t5_wb8_ign", oldest_ex_valid_o, 64'd0);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            idle();
            disp(2'b11, 2'b00);
            step();
        end
        idle();
        #1;
        check_eq("t6_count10", count_o, 64'd10);
        rstn_i = 1'b0;
        #1;
        check_eq("t6_rst_count", count_o, 64'd0);
        check_eq("t6_rst_ready", disp_ready_o, 64'd0);
        check_eq("t6_rst_idx", disp_index_o, 64'd0);
        check_eq("t6_rst_cvalid", commit_valid_o, 64'd0);
        check_eq("t6_rst_head", commit_head_o, 64'd0);
        check_eq("t6_rst_empty", empty_o, 64'd0);
        check_eq("t6_rst_full", full_o, 64'd0);
        step();
        step();
        rstn_i = 1'b1;
        disp(2'b11, 2'b00);
        #1;
        check_eq("t6_idx0", disp_index_o, {5'd1, 5'd0});
        check_eq("t6_ready", disp_ready_o, 64'd1);
        step();
        idle();
        #1;
        check_eq("t6_count2", count_o, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
